// File: rtl/nios2_oci_dct_pkg.sv
// Shared widths, atom encodings and frame layout for the OCI DCT trace packer.
// TRACE_TIMESTAMP_EN widens the frame with a 16-bit cycle timestamp.
package nios2_oci_dct_pkg;

    localparam int ATOM_W    = 2;
    localparam int MAX_ATOMS = 15;
    localparam int CNT_W     = 4;
    localparam int OVF_W     = 8;
    localparam int BUF_W     = ATOM_W * MAX_ATOMS;
    localparam int TS_W      = 16;
`ifdef TRACE_TIMESTAMP_EN
    localparam int FRAME_W   = TS_W + CNT_W + BUF_W;
`else
    localparam int FRAME_W   = CNT_W + BUF_W;
`endif

    localparam int FRM_BUF_LSB = 0;
    localparam int FRM_CNT_LSB = BUF_W;
    localparam int FRM_TS_LSB  = BUF_W + CNT_W;

    localparam logic [ATOM_W-1:0] DCT_NONE = 2'b00;
    localparam logic [ATOM_W-1:0] DCT_NT   = 2'b01;
    localparam logic [ATOM_W-1:0] DCT_TK   = 2'b10;
    localparam logic [ATOM_W-1:0] DCT_IND  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;
    localparam logic [CNT_W-1:0] CNT_FULL = 4'd15;
    localparam logic [OVF_W-1:0] OVF_ONE  = 8'd1;
    localparam logic [OVF_W-1:0] OVF_MAX  = 8'hFF;
    localparam logic [BUF_W-1:0] BUF_ZERO = 30'd0;

    // Saturating increment for the dropped-atom counter.
    function automatic logic [OVF_W-1:0] ovf_sat_inc(input logic [OVF_W-1:0] v);
        if (v == OVF_MAX) begin
            ovf_sat_inc = v;
        end else begin
            ovf_sat_inc = v + OVF_ONE;
        end
    endfunction

endpackage

// File: rtl/nios2_oci_dct_frame_reg.sv
// Single-entry valid/ready output register: load a frame, hold it until accepted,
// drain on ready.
module nios2_oci_dct_frame_reg
    import nios2_oci_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               ready,
    output logic               valid,
    output logic [FRAME_W-1:0] data
);

    // Load wins over drain so back-to-back frames leave no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= {FRAME_W{1'b0}};
        end else if (load) begin
            valid <= 1'b1;
            data  <= frame_in;
        end else if (ready) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit DCT atoms into a 15-atom buffer and hands full or flushed buffers to
// the frame register. Optional macro: TRACE_TIMESTAMP_EN (adds cycle timestamp).
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               atom_valid,
    input  logic [1:0]         atom_data,
    input  logic               flush,
    output logic [29:0]        dct_buffer,
    output logic [3:0]         dct_count,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] frame_data,
    output logic               overflow,
    output logic [7:0]         overflow_cnt
);

    logic [BUF_W-1:0]   buffer_r, buffer_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic               pending_r, pending_nxt_s;
    logic               ovf_r;
    logic [OVF_W-1:0]   ovf_cnt_r;
    logic               slot_free_s, full_s, handoff_s, accept_s, drop_s;
    logic [FRAME_W-1:0] frame_in_s;

    // Handoff and accept/drop decisions for this cycle.
    always_comb begin
        slot_free_s = !frame_valid | frame_ready;
        full_s      = (count_r == CNT_FULL);
        handoff_s   = (full_s | (pending_r & (count_r != CNT_ZERO))) & slot_free_s;
        accept_s    = atom_valid & (!full_s | handoff_s);
        drop_s      = atom_valid & full_s & !handoff_s;
    end

    // Next buffer state: clear on handoff, then pack any accepted atom on top.
    always_comb begin
        buffer_nxt_s = buffer_r;
        count_nxt_s  = count_r;
        if (handoff_s) begin
            buffer_nxt_s = BUF_ZERO;
            count_nxt_s  = CNT_ZERO;
        end else begin
            buffer_nxt_s = buffer_r;
            count_nxt_s  = count_r;
        end
        if (accept_s) begin
            buffer_nxt_s = {buffer_nxt_s[BUF_W-ATOM_W-1:0], atom_data};
            count_nxt_s  = count_nxt_s + CNT_ONE;
        end else begin
            count_nxt_s  = count_nxt_s;
        end
        // A flush only stays pending if something will be left to emit.
        if (flush) begin
            pending_nxt_s = (count_nxt_s != CNT_ZERO);
        end else if (handoff_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Packing buffer, count, flush request and overflow tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer_r  <= BUF_ZERO;
            count_r   <= CNT_ZERO;
            pending_r <= 1'b0;
            ovf_r     <= 1'b0;
            ovf_cnt_r <= {OVF_W{1'b0}};
        end else begin
            buffer_r  <= buffer_nxt_s;
            count_r   <= count_nxt_s;
            pending_r <= pending_nxt_s;
            if (drop_s) begin
                ovf_r     <= 1'b1;
                ovf_cnt_r <= ovf_sat_inc(ovf_cnt_r);
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r;

    // Free-running cycle timestamp, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_r <= 16'd0;
        end else begin
            ts_r <= ts_r + 16'd1;
        end
    end

    assign frame_in_s = {ts_r, count_r, buffer_r};
`else
    assign frame_in_s = {count_r, buffer_r};
`endif

    nios2_oci_dct_frame_reg u_frame_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (handoff_s),
        .frame_in (frame_in_s),
        .ready    (frame_ready),
        .valid    (frame_valid),
        .data     (frame_data)
    );

    assign dct_buffer   = buffer_r;
    assign dct_count    = count_r;
    assign overflow     = ovf_r;
    assign overflow_cnt = ovf_cnt_r;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Self-checking bench for nios2_oci_dct_packer: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_nios2_oci_dct_packer;
    import nios2_oci_dct_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               atom_valid;
    logic [1:0]         atom_data;
    logic               flush;
    logic [29:0]        dct_buffer;
    logic [3:0]         dct_count;
    logic               frame_valid;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_data;
    logic               overflow;
    logic [7:0]         overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: atoms held in a queue, frame slot, flush request.
    logic [1:0]         m_q[$];
    bit                 m_fv;
    logic [FRAME_W-1:0] m_frame;
    bit                 m_pend;
    bit                 m_ovf;
    int                 m_ovf_cnt;
    int                 m_ts;

    always #5 clk = ~clk;

    nios2_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .atom_valid   (atom_valid),
        .atom_data    (atom_data),
        .flush        (flush),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .overflow     (overflow),
        .overflow_cnt (overflow_cnt)
    );

    function automatic logic [29:0] q_value();
        logic [29:0] v = 30'd0;
        foreach (m_q[i]) v = (v << 2) | {28'd0, m_q[i]};
        return v;
    endfunction

    function automatic logic [3:0] q_count();
        int n = m_q.size();
        return n[3:0];
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_fv = 0; m_frame = '0; m_pend = 0; m_ovf = 0; m_ovf_cnt = 0; m_ts = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; atom_valid = 1'b0; atom_data = 2'b00; flush = 1'b0; frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit v, input logic [1:0] d, input bit f, input bit r);
        int n;
        bit slot, ho;
        atom_valid = v; atom_data = d; flush = f; frame_ready = r;
        n    = m_q.size();
        slot = !m_fv || r;
        ho   = ((n == 15) || (m_pend && n != 0)) && slot;
        if (m_fv && r) m_fv = 0;
        if (ho) begin
`ifdef TRACE_TIMESTAMP_EN
            m_frame = {m_ts[15:0], q_count(), q_value()};
`else
            m_frame = {q_count(), q_value()};
`endif
            m_fv = 1;
            m_q.delete();
        end
        if (v) begin
            if (m_q.size() < 15) m_q.push_back(d);
            else begin
                m_ovf = 1;
                if (m_ovf_cnt < 255) m_ovf_cnt++;
            end
        end
        if (f) m_pend = (m_q.size() != 0);
        else if (ho) m_pend = 0;
        m_ts = (m_ts + 1) % 65536;
        @(posedge clk);
        #1;
        atom_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({dct_buffer, dct_count, frame_valid, frame_data, overflow, overflow_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got buf=%h cnt=%0d fv=%b fd=%h ovf=%b oc=%0d, want all zero",
                     dct_buffer, dct_count, frame_valid, frame_data, overflow, overflow_cnt);
        end
    endtask

    task automatic test_full_frame();
        logic [33:0] exp34 = {4'd15, 30'h15555555};
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b1, 2'b01, 1'b0, 1'b1);
        n_checks++;
        if (dct_count !== 4'd15 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_fill: got cnt=%0d fv=%b, want 15 0", dct_count, frame_valid);
        end
        step(1'b0, 2'b00, 1'b0, 1'b1);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_data[33:0] !== exp34 || dct_count !== 4'd0) begin
            n_fail++;
            $display("FAIL full_frame: got fv=%b fd=%h cnt=%0d, want 1 %h 0",
                     frame_valid, frame_data[33:0], dct_count, exp34);
        end
`ifdef TRACE_TIMESTAMP_EN
        n_checks++;
        if (frame_data[49:34] !== 16'd15) begin
            n_fail++;
            $display("FAIL frame_ts: got %0d want 15", frame_data[49:34]);
        end
`endif
    endtask

    task automatic test_flush();
        int frames = 0;
        do_reset();
        step(1'b1, 2'b10, 1'b0, 1'b1);
        step(1'b1, 2'b11, 1'b0, 1'b1);
        step(1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_data[33:0] !== {4'd3, 30'h0000002D}) begin
            n_fail++;
            $display("FAIL flush_frame: got fv=%b fd=%h, want 1 %h",
                     frame_valid, frame_data[33:0], {4'd3, 30'h0000002D});
        end
        for (int i = 0; i < 5; i++) begin
            if (frame_valid) frames++;
            step(1'b0, 2'b00, 1'b0, 1'b1);
        end
        n_checks++;
        if (frames != 1) begin
            n_fail++;
            $display("FAIL flush_single: got %0d frames, want 1", frames);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_data[33:30] !== 4'd15 || dct_count !== 4'd15 ||
            overflow !== 1'b1 || overflow_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL backpressure: got fv=%b fcnt=%0d cnt=%0d ovf=%b oc=%0d, want 1 15 15 1 2",
                     frame_valid, frame_data[33:30], dct_count, overflow, overflow_cnt);
        end
        step(1'b0, 2'b00, 1'b0, 1'b1);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_data[33:0] !== {4'd15, 30'h3FFFFFFF} || dct_count !== 4'd0) begin
            n_fail++;
            $display("FAIL second_frame: got fv=%b fd=%h cnt=%0d, want 1 %h 0",
                     frame_valid, frame_data[33:0], dct_count, {4'd15, 30'h3FFFFFFF});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 22; i++) step(1'b1, 2'($urandom_range(3)), 1'b0, 1'b0);
        n_checks++;
        if (dct_count !== 4'd7 || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got cnt=%0d fv=%b, want 7 1", dct_count, frame_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (dct_count !== 4'd0 || dct_buffer !== 30'd0 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d buf=%h fv=%b, want 0 0 0",
                     dct_count, dct_buffer, frame_valid);
        end
        do_reset();
    endtask

    task automatic test_handoff_atom();
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b1, 2'b11, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_data[33:30] !== 4'd15 ||
            dct_count !== 4'd1 || dct_buffer !== 30'd2) begin
            n_fail++;
            $display("FAIL handoff_atom: got fv=%b fcnt=%0d cnt=%0d buf=%h, want 1 15 1 2",
                     frame_valid, frame_data[33:30], dct_count, dct_buffer);
        end
    endtask

    task automatic test_empty_flush();
        int seen = 0;
        do_reset();
        step(1'b0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b00, 1'b0, 1'b1);
            if (frame_valid) seen++;
        end
        step(1'b1, 2'b01, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 1'b0, 1'b1);
            if (frame_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || dct_count !== 4'd1) begin
            n_fail++;
            $display("FAIL empty_flush: got %0d valid cycles cnt=%0d, want 0 1", seen, dct_count);
        end
    endtask

    task automatic test_random();
        bit v, f, r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(3) != 0);
            f = ($urandom_range(15) == 0);
            r = (i < 200) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 1);
            step(v, 2'($urandom_range(3)), f, r);
            n_checks++;
            if ({dct_buffer, dct_count, frame_valid, frame_data, overflow, overflow_cnt} !==
                {q_value(), q_count(), m_fv, m_frame, m_ovf, 8'(m_ovf_cnt)}) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got buf=%h cnt=%0d fv=%b fd=%h ovf=%b oc=%0d, want buf=%h cnt=%0d fv=%b fd=%h ovf=%b oc=%0d",
                         i, dct_buffer, dct_count, frame_valid, frame_data, overflow, overflow_cnt,
                         q_value(), q_count(), m_fv, m_frame, m_ovf, m_ovf_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_backpressure();
        test_async_reset();
        test_handoff_atom();
        test_empty_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
